// File: rtl/mux8way_rr_collector.sv
// ---------------------------------------------------------------------------
// mux8way_rr_collector
//
// Gathers words from eight producer channels onto a single output stream.
// A round-robin arbiter grants at most one requesting channel per cycle and
// the winning word is captured in a one-deep registered output stage. The
// output is tagged with the 3-bit index of the channel that supplied it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   [7:0]         channel k has a word
//   in_data    [8*WIDTH-1:0] channel k word at [k*WIDTH +: WIDTH]
//   in_ready   [7:0]         one-hot (or zero) grant to the producers
//   out_valid                output register holds a word
//   out_data   [WIDTH-1:0]   captured word
//   out_sel    [2:0]         source channel of out_data (a=0 ... h=7)
//   out_ready                consumer accepts the held word
// ---------------------------------------------------------------------------
module mux8way_rr_collector #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         ptr_q, ptr_d;

  logic [WIDTH-1:0]   words_s [8];
  logic               can_load_s;
  logic               grant_found_s;
  logic [2:0]         grant_idx_s;
  logic [2:0]         cand_s;
  logic               hit_s;
  logic               grant_s;

  // Unpack the flat input bus into one word per channel.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      words_s[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  // The output stage can take a new word when empty or when it is draining.
  assign can_load_s = (state_q == EMPTY) || out_ready;

  // Round-robin scan starting at ptr; first valid channel wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    cand_s        = 3'd0;
    hit_s         = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand_s        = ptr_q + 3'(i);
      hit_s         = !grant_found_s && in_valid[cand_s];
      grant_idx_s   = hit_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // A grant only exists when the stage can load; reset suppresses all grants
  // so in_ready stays low for the whole reset period.
  assign grant_s = grant_found_s && can_load_s && !reset;

  // One-hot ready decode of the winning channel.
  always_comb begin
    in_ready = 8'd0;
    if (grant_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = 8'd0;
    end
  end

  // Next-state logic for the output stage and arbitration pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: begin
        if (grant_s) begin
          state_d = FULL;
          data_d  = words_s[grant_idx_s];
          sel_d   = grant_idx_s;
          ptr_d   = grant_idx_s + 3'd1;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (grant_s) begin
          // Old word leaves and the new one loads on the same edge.
          state_d = FULL;
          data_d  = words_s[grant_idx_s];
          sel_d   = grant_idx_s;
          ptr_d   = grant_idx_s + 3'd1;
        end else if (out_ready) begin
          // Drain only: data and sel keep their last values.
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, data, tag and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: doc/mux8way_rr_collector.md
Name: mux8way_rr_collector

Overview:
- Collects words from eight producer channels onto one output stream. It is the gather-side counterpart of the 8-way demultiplexer fabric.
- Each channel has a valid/ready handshake. A round-robin arbiter picks one requesting channel per transfer.
- The winning word is captured in a registered output stage, tagged with its 3-bit source index.
- It sits where eight Hack-word producers share one consumer, for example eight peripheral ports feeding one memory-write path.

Parameters:
WIDTH, 16, data word width in bits (Hack word).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  8  bit k = channel k has a word.
in_data  input  8*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
in_ready  output  8  one-hot (or zero) grant; channel k word is accepted on the edge where in_valid[k] & in_ready[k].
out_valid  output  1  output register holds a word.
out_data  output  WIDTH  captured word.
out_sel  output  3  index of the channel that supplied out_data (matches DMux8Way sel encoding: a=0 ... h=7).
out_ready  input  1  consumer accepts; transfer on the edge where out_valid & out_ready.

Behaviour:
- Reset (async, active-high), asserted immediately regardless of clk:
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready=8'b0 for as long as reset is high.
- Control is two-state, held in out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = !out_valid | out_ready. It is a combinational function of state and out_ready.
- Arbitration (combinational, only when can_load=1):
  - Scan channels ptr, ptr+1, ..., ptr+7, all mod 8.
  - The first k with in_valid[k]=1 gets in_ready[k]=1. All other in_ready bits are 0.
  - If no channel is valid, or can_load=0, then in_ready=0.
  - in_ready never depends on in_data.
- Load, on the edge where a grant k exists:
  - out_data<=in_data[k], out_sel<=k, out_valid<=1, ptr<=(k+1) mod 8 (3-bit wrap, 7 -> 0).
- Drain without reload, on the edge where out_valid & out_ready and there is no grant:
  - out_valid<=0.
  - out_data and out_sel hold their last values.
  - ptr unchanged.
- FULL and !out_ready:
  - All outputs hold, in_ready=0.
  - ptr must not advance while stalled.
- Simultaneous drain and load (FULL, out_ready=1, some in_valid=1):
  - The old word leaves and the new word loads on the same edge.
  - out_valid stays 1, giving full throughput of one word per cycle.
- Latency: a word granted at edge N is visible on out_data after edge N.
  - Minimum in-to-out latency is 1 cycle. There is no combinational path from in_data to out_data.
- Fairness: with all 8 channels continuously valid and out_ready=1, grants run 0,1,2,...,7,0,...
  - No channel waits more than 7 transfers.
- in_valid deasserting without a grant is allowed; the block keeps no per-channel state.
- Reset mid-transfer: any held word is discarded and ptr returns to 0.
- After reset is released, the first grant can occur on the first clk edge.

Test Plan:
- Reset and single channel:
  - Assert reset → out_valid=0, out_sel=0, out_data=0, in_ready=0.
  - Release, in_valid=8'b0000_0100, ch2 data=16'hA5A5, out_ready=1 → in_ready=8'b0000_0100, next cycle out_valid=1, out_data=A5A5, out_sel=2; ptr now 3.
- Round robin, all valid:
  - in_valid=8'hFF, ch k data=16'h1000+k, out_ready=1 for 10 cycles → out_sel sequence 0,1,2,3,4,5,6,7,0,1, out_data 1000..1007,1000,1001, out_valid continuously 1.
- Backpressure:
  - out FULL with sel=3, in_valid=8'hFF, out_ready=0 for 4 cycles → in_ready=0, out_data/out_sel stable, ptr stays 4.
  - Raise out_ready → next word from ch4.
- Wrap-around skip:
  - ptr=6 (after a ch5 grant), in_valid=8'b0000_0011 → grant ch0 (in_ready=8'b0000_0001), then ptr=1, and the next grant is ch1.
- Drain to empty:
  - One word loaded, then in_valid=0 and out_ready=1 → out_valid falls to 0 after one edge, out_data/out_sel unchanged.
- Async reset mid-stream:
  - Assert reset between edges during the all-valid stream → out_valid drops to 0 immediately, without waiting for clk.
  - After release the first grant is ch0 again.
